bot_evt_sync_hub: RTL and testbench

- Parametrised, multi-channel successor to the single IO_BotUpdt_Sync set/clear flop.
- Each channel has an optional input synchroniser and an edge or level event detector.
- Each channel also has a sticky pending flag, a data snapshot captured on the event, and a saturating missed-event counter.
- Pending flags are masked into one IRQ with a lowest-index channel ID; sits between rojobot-style update sources and the swervolf_core interrupt/GPIO interface.

---
 rtl/bot_evt_sync_hub.sv | 172 +++++++++++++++++
 tb/tb_bot_evt_sync_hub.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bot_evt_sync_hub.sv
// ---------------------------------------------------------------------------
// bot_evt_sync_hub
//
// Multi-channel event hub that replaces a single update set/clear flop.
// Each channel optionally synchronises its event input, detects a rising
// edge or a level, raises a sticky pending flag, snapshots the channel data
// word on the event, and counts events that arrive while the previous one is
// still unacknowledged (saturating). Pending flags are masked and combined
// into one registered interrupt plus the lowest-index active channel ID.
//
// Ports
//   clk          : single clock
//   rst          : asynchronous active-high reset
//   evt_i        : per-channel update strobe / level
//   data_i       : per-channel data, channel c at [c*DATA_W +: DATA_W]
//   ack_i        : per-channel acknowledge, clears pending
//   mask_i       : per-channel interrupt enable
//   clr_miss_i   : per-channel missed-event counter clear
//   pending_o    : sticky pending flags
//   snap_o       : captured data, same packing as data_i
//   miss_cnt_o   : missed-event counters, channel c at [c*CNT_W +: CNT_W]
//   irq_o        : registered OR of pending & mask
//   irq_id_o     : registered lowest-index pending unmasked channel
// ---------------------------------------------------------------------------
module bot_evt_sync_hub #(
    parameter int              N_CH        = 2,
    parameter int              DATA_W      = 32,
    parameter int              CNT_W       = 4,
    parameter int              SYNC_STAGES = 2,
    parameter logic [N_CH-1:0] EDGE_MODE   = {N_CH{1'b1}},
    localparam int             ID_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH-1:0]          evt_i,
    input  logic [N_CH*DATA_W-1:0]   data_i,
    input  logic [N_CH-1:0]          ack_i,
    input  logic [N_CH-1:0]          mask_i,
    input  logic [N_CH-1:0]          clr_miss_i,
    output logic [N_CH-1:0]          pending_o,
    output logic [N_CH*DATA_W-1:0]   snap_o,
    output logic [N_CH*CNT_W-1:0]    miss_cnt_o,
    output logic                     irq_o,
    output logic [ID_W-1:0]          irq_id_o
);

    // Synchroniser depth used for declarations; never zero so that the
    // vector stays legal even when the synchroniser is bypassed.
    localparam int SS = (SYNC_STAGES > 0) ? SYNC_STAGES : 1;

    logic [N_CH-1:0]        evt_s;
    logic [N_CH-1:0]        evt_det;

    logic [N_CH-1:0]        hist_q;
    logic [N_CH-1:0]        pending_q;
    logic [N_CH-1:0]        pending_d;
    logic [N_CH*DATA_W-1:0] snap_q;
    logic [N_CH*DATA_W-1:0] snap_d;
    logic [N_CH*CNT_W-1:0]  miss_q;
    logic [N_CH*CNT_W-1:0]  miss_d;
    logic                   irq_q;
    logic                   irq_d;
    logic [ID_W-1:0]        irq_id_q;
    logic [ID_W-1:0]        irq_id_d;

    genvar gi;

    // -----------------------------------------------------------------------
    // Input synchronisers
    // -----------------------------------------------------------------------
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign evt_s = evt_i;
        end else begin : g_sync
            for (gi = 0; gi < N_CH; gi++) begin : g_ch
                logic [SS-1:0] sync_q;

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        sync_q <= '0;
                    end else begin
                        for (int s = SS - 1; s > 0; s--) begin
                            sync_q[s] <= sync_q[s-1];
                        end
                        sync_q[0] <= evt_i[gi];
                    end
                end

                assign evt_s[gi] = sync_q[SS-1];
            end
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Per-channel event detect and next-state
    // -----------------------------------------------------------------------
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_chan
            logic [CNT_W-1:0] miss_cur;
            logic             miss_inc;

            // Edge channels fire once per 0->1 of the synchronised input;
            // level channels fire on every cycle the input is high.
            if (EDGE_MODE[gi]) begin : g_edge
                assign evt_det[gi] = evt_s[gi] & ~hist_q[gi];
            end else begin : g_level
                assign evt_det[gi] = evt_s[gi];
            end

            // A new event beats a simultaneous acknowledge, so the flag
            // never drops while fresh data has just been captured.
            assign pending_d[gi] = evt_det[gi] | (pending_q[gi] & ~ack_i[gi]);

            assign snap_d[gi*DATA_W +: DATA_W] = evt_det[gi]
                ? data_i[gi*DATA_W +: DATA_W]
                : snap_q[gi*DATA_W +: DATA_W];

            // An event counts as missed only if the previous one is still
            // pending and is not being acknowledged in this same cycle.
            assign miss_cur = miss_q[gi*CNT_W +: CNT_W];
            assign miss_inc = evt_det[gi] & pending_q[gi] & ~ack_i[gi] & ~(&miss_cur);

            assign miss_d[gi*CNT_W +: CNT_W] = clr_miss_i[gi] ? '0
                : miss_inc ? (miss_cur + CNT_W'(1))
                : miss_cur;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Interrupt combine: lowest-index pending unmasked channel wins; the ID
    // holds its previous value when nothing is active.
    // -----------------------------------------------------------------------
    always_comb begin
        logic [N_CH-1:0] hit;
        hit      = pending_q & mask_i;
        irq_d    = |hit;
        irq_id_d = irq_id_q;
        for (int c = N_CH - 1; c >= 0; c--) begin
            if (hit[c]) begin
                irq_id_d = ID_W'(c);
            end
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q    <= '0;
            pending_q <= '0;
            snap_q    <= '0;
            miss_q    <= '0;
            irq_q     <= 1'b0;
            irq_id_q  <= '0;
        end else begin
            hist_q    <= evt_s;
            pending_q <= pending_d;
            snap_q    <= snap_d;
            miss_q    <= miss_d;
            irq_q     <= irq_d;
            irq_id_q  <= irq_id_d;
        end
    end

    assign pending_o  = pending_q;
    assign snap_o     = snap_q;
    assign miss_cnt_o = miss_q;
    assign irq_o      = irq_q;
    assign irq_id_o   = irq_id_q;

endmodule

// File: tb/tb_bot_evt_sync_hub.sv
// ---------------------------------------------------------------------------
// Testbench for bot_evt_sync_hub: two channels, two synchroniser stages,
// channel 0 in edge mode and channel 1 in level mode. A directed per-cycle
// vector table covers reset, edge latency, snapshot, ack, irq priority and
// masking; hand sequences cover collisions, saturation, level behaviour and
// reset in mid-operation.
// ---------------------------------------------------------------------------
module tb_bot_evt_sync_hub;

    localparam int N_CH   = 2;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    logic                   clk;
    logic                   rst;
    logic [N_CH-1:0]        evt_i;
    logic [N_CH*DATA_W-1:0] data_i;
    logic [N_CH-1:0]        ack_i;
    logic [N_CH-1:0]        mask_i;
    logic [N_CH-1:0]        clr_miss_i;
    logic [N_CH-1:0]        pending_o;
    logic [N_CH*DATA_W-1:0] snap_o;
    logic [N_CH*CNT_W-1:0]  miss_cnt_o;
    logic                   irq_o;
    logic [0:0]             irq_id_o;

    int n_cmp = 0;
    int n_err = 0;

    bot_evt_sync_hub #(
        .N_CH        (N_CH),
        .DATA_W      (DATA_W),
        .CNT_W       (CNT_W),
        .SYNC_STAGES (2),
        .EDGE_MODE   (2'b01)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .evt_i      (evt_i),
        .data_i     (data_i),
        .ack_i      (ack_i),
        .mask_i     (mask_i),
        .clr_miss_i (clr_miss_i),
        .pending_o  (pending_o),
        .snap_o     (snap_o),
        .miss_cnt_o (miss_cnt_o),
        .irq_o      (irq_o),
        .irq_id_o   (irq_id_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  evt;
        logic [1:0]  ack;
        logic [1:0]  mask;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  x_pend;
        logic        x_irq;
        logic        x_id;
        logic [31:0] x_s0;
        logic [31:0] x_s1;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Advance one clock; outputs are sampled on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One-cycle strobe on a channel with data held until the event lands.
    task automatic pulse(input int ch, input logic [31:0] d);
        data_i[ch*DATA_W +: DATA_W] = d;
        evt_i[ch] = 1'b1;
        step();
        evt_i[ch] = 1'b0;
        step();
        step();
    endtask

    function automatic vec_t mk(input logic [1:0] evt, input logic [1:0] ack,
                                input logic [1:0] mask, input logic [31:0] d0,
                                input logic [31:0] d1, input logic [1:0] x_pend,
                                input logic x_irq, input logic x_id,
                                input logic [31:0] x_s0, input logic [31:0] x_s1);
        vec_t v;
        v.evt = evt; v.ack = ack; v.mask = mask; v.d0 = d0; v.d1 = d1;
        v.x_pend = x_pend; v.x_irq = x_irq; v.x_id = x_id;
        v.x_s0 = x_s0; v.x_s1 = x_s1;
        return v;
    endfunction

    initial begin
        //              evt    ack    mask   d0            d1            pend   irq   id    snap0         snap1
        tbl[0]  = mk(2'b00, 2'b00, 2'b11, 32'hA5A5_0001, 32'h0,        2'b00, 1'b0, 1'b0, 32'h0,        32'h0);
        tbl[1]  = mk(2'b01, 2'b00, 2'b11, 32'hA5A5_0001, 32'h0,        2'b00, 1'b0, 1'b0, 32'h0,        32'h0);
        tbl[2]  = mk(2'b01, 2'b00, 2'b11, 32'hA5A5_0001, 32'h0,        2'b00, 1'b0, 1'b0, 32'h0,        32'h0);
        tbl[3]  = mk(2'b01, 2'b00, 2'b11, 32'hA5A5_0001, 32'h0,        2'b01, 1'b0, 1'b0, 32'hA5A5_0001, 32'h0);
        tbl[4]  = mk(2'b01, 2'b00, 2'b11, 32'h0,        32'h0,        2'b01, 1'b1, 1'b0, 32'hA5A5_0001, 32'h0);
        tbl[5]  = mk(2'b00, 2'b01, 2'b11, 32'h0,        32'h0,        2'b00, 1'b1, 1'b0, 32'hA5A5_0001, 32'h0);
        tbl[6]  = mk(2'b00, 2'b00, 2'b11, 32'h0,        32'h0,        2'b00, 1'b0, 1'b0, 32'hA5A5_0001, 32'h0);
        tbl[7]  = mk(2'b11, 2'b00, 2'b11, 32'h1111_0000, 32'h2222_0000, 2'b00, 1'b0, 1'b0, 32'hA5A5_0001, 32'h0);
        tbl[8]  = mk(2'b00, 2'b00, 2'b11, 32'h1111_0000, 32'h2222_0000, 2'b00, 1'b0, 1'b0, 32'hA5A5_0001, 32'h0);
        tbl[9]  = mk(2'b00, 2'b00, 2'b11, 32'h1111_0000, 32'h2222_0000, 2'b11, 1'b0, 1'b0, 32'h1111_0000, 32'h2222_0000);
        tbl[10] = mk(2'b00, 2'b00, 2'b11, 32'hDEAD_BEEF, 32'hCAFE_F00D, 2'b11, 1'b1, 1'b0, 32'h1111_0000, 32'h2222_0000);
        tbl[11] = mk(2'b00, 2'b00, 2'b10, 32'hDEAD_BEEF, 32'hCAFE_F00D, 2'b11, 1'b1, 1'b1, 32'h1111_0000, 32'h2222_0000);
        tbl[12] = mk(2'b00, 2'b00, 2'b00, 32'hDEAD_BEEF, 32'hCAFE_F00D, 2'b11, 1'b0, 1'b1, 32'h1111_0000, 32'h2222_0000);
        tbl[13] = mk(2'b00, 2'b01, 2'b00, 32'hDEAD_BEEF, 32'hCAFE_F00D, 2'b10, 1'b0, 1'b1, 32'h1111_0000, 32'h2222_0000);
        tbl[14] = mk(2'b00, 2'b00, 2'b11, 32'hDEAD_BEEF, 32'hCAFE_F00D, 2'b10, 1'b1, 1'b1, 32'h1111_0000, 32'h2222_0000);
        tbl[15] = mk(2'b00, 2'b10, 2'b11, 32'hDEAD_BEEF, 32'hCAFE_F00D, 2'b00, 1'b1, 1'b1, 32'h1111_0000, 32'h2222_0000);
        tbl[16] = mk(2'b00, 2'b11, 2'b11, 32'hDEAD_BEEF, 32'hCAFE_F00D, 2'b00, 1'b0, 1'b1, 32'h1111_0000, 32'h2222_0000);

        rst        = 1'b1;
        evt_i      = '0;
        data_i     = '0;
        ack_i      = '0;
        mask_i     = 2'b11;
        clr_miss_i = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // ---- post-reset idle: everything stays zero for 10 cycles ----
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_pend", 32'(pending_o), 32'h0);
            chk("idle_irq", {irq_o, irq_id_o}, 32'h0);
            chk("idle_snap0", snap_o[31:0], 32'h0);
            chk("idle_snap1", snap_o[63:32], 32'h0);
            chk("idle_miss", 32'(miss_cnt_o), 32'h0);
        end
        $display("idle: 10 cycles after reset checked");

        // ---- table-driven per-cycle vectors ----
        for (int i = 0; i < 17; i++) begin
            evt_i          = tbl[i].evt;
            ack_i          = tbl[i].ack;
            mask_i         = tbl[i].mask;
            data_i[31:0]   = tbl[i].d0;
            data_i[63:32]  = tbl[i].d1;
            step();
            $display("vec %0d: evt=%b ack=%b mask=%b -> pend=%b irq=%b id=%0d snap0=%h snap1=%h miss=%h",
                     i, tbl[i].evt, tbl[i].ack, tbl[i].mask, pending_o, irq_o, irq_id_o,
                     snap_o[31:0], snap_o[63:32], miss_cnt_o);
            chk($sformatf("vec%0d_pend", i), 32'(pending_o), 32'(tbl[i].x_pend));
            chk($sformatf("vec%0d_irq", i), 32'(irq_o), 32'(tbl[i].x_irq));
            chk($sformatf("vec%0d_id", i), 32'(irq_id_o), 32'(tbl[i].x_id));
            chk($sformatf("vec%0d_snap0", i), snap_o[31:0], tbl[i].x_s0);
            chk($sformatf("vec%0d_snap1", i), snap_o[63:32], tbl[i].x_s1);
            chk($sformatf("vec%0d_miss", i), 32'(miss_cnt_o), 32'h0);
        end
        ack_i  = '0;
        mask_i = 2'b11;

        // ---- ack/event collision on ch1 ----
        pulse(1, 32'h1234_5678);
        chk("coll_pre_pend1", 32'(pending_o[1]), 32'h1);
        chk("coll_pre_snap1", snap_o[63:32], 32'h1234_5678);
        data_i[63:32] = 32'h0000_00FF;
        evt_i[1] = 1'b1;
        step();
        evt_i[1] = 1'b0;
        step();
        ack_i[1] = 1'b1;            // lands on the same edge as the event
        step();
        ack_i[1] = 1'b0;
        $display("collision: pend=%b snap1=%h miss1=%0d", pending_o, snap_o[63:32], miss_cnt_o[7:4]);
        chk("coll_pend1", 32'(pending_o[1]), 32'h1);
        chk("coll_snap1", snap_o[63:32], 32'h0000_00FF);
        chk("coll_miss1", 32'(miss_cnt_o[7:4]), 32'h0);
        pulse(1, 32'h0000_0055);
        chk("coll_miss1_after", 32'(miss_cnt_o[7:4]), 32'h1);
        chk("coll_snap1_after", snap_o[63:32], 32'h0000_0055);
        ack_i[1] = 1'b1;
        step();
        ack_i[1] = 1'b0;
        chk("coll_ack_clears", 32'(pending_o[1]), 32'h0);

        // ---- missed-event saturation on ch0 ----
        for (int i = 0; i < 20; i++) begin
            pulse(0, 32'h100 + 32'(i));
        end
        $display("saturation: 20 edges -> pend0=%b miss0=%0d", pending_o[0], miss_cnt_o[3:0]);
        chk("sat_miss0", 32'(miss_cnt_o[3:0]), 32'd15);
        chk("sat_snap0", snap_o[31:0], 32'h113);
        evt_i[0] = 1'b1;
        step();
        evt_i[0] = 1'b0;
        step();
        clr_miss_i[0] = 1'b1;       // clear coincides with the event edge
        step();
        clr_miss_i[0] = 1'b0;
        $display("clear+edge: pend0=%b miss0=%0d miss1=%0d", pending_o[0], miss_cnt_o[3:0], miss_cnt_o[7:4]);
        chk("clr_miss0", 32'(miss_cnt_o[3:0]), 32'h0);
        chk("clr_pend0", 32'(pending_o[0]), 32'h1);
        chk("clr_miss1_untouched", 32'(miss_cnt_o[7:4]), 32'h1);

        // ---- level mode on ch1 ----
        clr_miss_i[1] = 1'b1;
        step();
        clr_miss_i[1] = 1'b0;
        data_i[63:32] = 32'h0000_0077;
        evt_i[1] = 1'b1;
        repeat (5) step();
        evt_i[1] = 1'b0;
        repeat (2) step();
        $display("level: 5 cycles high -> pend1=%b miss1=%0d", pending_o[1], miss_cnt_o[7:4]);
        chk("lvl_pend1", 32'(pending_o[1]), 32'h1);
        chk("lvl_miss1", 32'(miss_cnt_o[7:4]), 32'd4);
        evt_i[1] = 1'b1;
        step();
        step();
        ack_i[1] = 1'b1;
        step();
        ack_i[1] = 1'b0;
        evt_i[1] = 1'b0;
        $display("level+ack: pend1=%b miss1=%0d", pending_o[1], miss_cnt_o[7:4]);
        chk("lvl_ack_pend1", 32'(pending_o[1]), 32'h1);
        chk("lvl_ack_miss1", 32'(miss_cnt_o[7:4]), 32'd4);
        repeat (3) step();
        chk("lvl_tail_miss1", 32'(miss_cnt_o[7:4]), 32'd6);

        // ---- mid-operation reset ----
        for (int i = 0; i < 3; i++) begin
            pulse(0, 32'h200 + 32'(i));
        end
        chk("pre_rst_miss0", 32'(miss_cnt_o[3:0]), 32'd3);
        chk("pre_rst_pend0", 32'(pending_o[0]), 32'h1);
        chk("pre_rst_irq", 32'(irq_o), 32'h1);
        #2 rst = 1'b1;
        #1;
        $display("async reset: pend=%b irq=%b id=%0d miss=%h snap=%h", pending_o, irq_o, irq_id_o, miss_cnt_o, snap_o);
        chk("rst_pend", 32'(pending_o), 32'h0);
        chk("rst_irq", {irq_o, irq_id_o}, 32'h0);
        chk("rst_miss", 32'(miss_cnt_o), 32'h0);
        chk("rst_snap0", snap_o[31:0], 32'h0);
        chk("rst_snap1", snap_o[63:32], 32'h0);

        // ---- evt_i held high through reset release fires exactly once ----
        evt_i[0]     = 1'b1;
        data_i[31:0] = 32'h0BAD_F00D;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) step();
        evt_i[0] = 1'b0;
        $display("release with evt high: pend=%b miss0=%0d snap0=%h", pending_o, miss_cnt_o[3:0], snap_o[31:0]);
        chk("rel_pend0", 32'(pending_o[0]), 32'h1);
        chk("rel_miss0", 32'(miss_cnt_o[3:0]), 32'h0);
        chk("rel_snap0", snap_o[31:0], 32'h0BAD_F00D);
        chk("rel_pend1", 32'(pending_o[1]), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
